// File: rtl/clock_ratio_detector.sv
`default_nettype none
// ============================================================================
// Module      : clock_ratio_detector
// Description : Recovers the divider select code from a 1-cycle pulse train.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_ratio_detector #(
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = 12,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    output logic [1:0]       sel_det,
    output logic             locked,
    output logic [CNT_W-1:0] period,
    output logic             err
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [3:0]       C_LOCK    = 4'(LOCK_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_din_d;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_cand;
    logic [3:0]       r_mcnt;
    logic [1:0]       r_sel_det;
    logic             r_locked;
    logic [CNT_W-1:0] r_period;
    logic             r_err;

    logic             w_edge;
    logic             w_wide;
    logic             w_timeout;
    logic [CNT_W-1:0] w_p;
    logic             w_legal;
    logic [1:0]       w_code;
    logic             w_match;
    logic [3:0]       w_mnext;

    assign w_edge    = din & ~r_din_d;
    assign w_wide    = din & r_din_d;
    assign w_timeout = (r_cnt == C_TO_LAST) && !w_edge;
    // Saturated count keeps p saturated too, so it never wraps into a legal value
    assign w_p       = (r_cnt == C_CNT_MAX) ? C_CNT_MAX : r_cnt + 1'b1;
    assign w_match   = (w_p == r_cand);
    assign w_mnext   = w_match ? r_mcnt + 4'd1 : 4'd1;

    always_comb begin
        w_legal = 1'b1;
        w_code  = 2'b00;
        case (w_p)
            CNT_W'(3): w_code = 2'b00;
            CNT_W'(2): w_code = 2'b01;
            CNT_W'(4): w_code = 2'b10;
            CNT_W'(8): w_code = 2'b11;
            default:   w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_din_d   <= 1'b0;
            r_cnt     <= '0;
            r_cand    <= '0;
            r_mcnt    <= '0;
            r_sel_det <= 2'b00;
            r_locked  <= 1'b0;
            r_period  <= '0;
            r_err     <= 1'b0;
        end else begin
            r_din_d <= din;
            r_err   <= 1'b0;
            if (w_edge)
                r_cnt <= '0;
            else if (r_cnt != C_CNT_MAX)
                r_cnt <= r_cnt + 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (w_edge) begin
                        r_state <= ST_ACQ;
                        r_mcnt  <= '0;
                    end
                end
                default: begin
                    if (w_wide || w_timeout) begin
                        r_err    <= 1'b1;
                        r_locked <= 1'b0;
                        r_mcnt   <= '0;
                        r_state  <= ST_IDLE;
                    end else if (w_edge) begin
                        r_period <= w_p;
                        if (!w_legal) begin
                            r_err    <= 1'b1;
                            r_locked <= 1'b0;
                            r_mcnt   <= '0;
                            r_state  <= ST_ACQ;
                        end else if (r_state == ST_ACQ) begin
                            r_cand <= w_p;
                            r_mcnt <= w_mnext;
                            if (w_mnext == C_LOCK) begin
                                r_state   <= ST_LOCKED;
                                r_sel_det <= w_code;
                                r_locked  <= 1'b1;
                            end
                        end else if (!w_match) begin
                            r_locked <= 1'b0;
                            r_cand   <= w_p;
                            r_mcnt   <= 4'd1;
                            r_state  <= ST_ACQ;
                        end
                    end
                end
            endcase
        end
    end

    assign sel_det = r_sel_det;
    assign locked  = r_locked;
    assign period  = r_period;
    assign err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_clock_ratio_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_ratio_detector
// Description : Directed self-checking bench for clock_ratio_detector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_ratio_detector;

    logic       clk;
    logic       rst_n;
    logic       din;
    logic [1:0] sel_det;
    logic       locked;
    logic [3:0] period;
    logic       err;

    int checks;
    int failures;
    int err_cnt;

    clock_ratio_detector #(
        .LOCK_COUNT (4),
        .TIMEOUT    (12),
        .CNT_W      (4)
    ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .din     (din),
        .sel_det (sel_det),
        .locked  (locked),
        .period  (period),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One system-clock cycle: drive din, clock it in, settle past the edge
    task automatic cyc(input logic d);
        din = d;
        @(posedge clk);
        #1;
        if (err) err_cnt++;
    endtask

    task automatic gap(input int n);
        repeat (n) cyc(1'b0);
    endtask

    // n rising edges each followed by (per-1) low cycles
    task automatic send(input int per, input int n);
        repeat (n) begin
            cyc(1'b1);
            gap(per - 1);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(1'b0);
        cyc(1'b0);
        rst_n = 1'b1;
        err_cnt = 0;
    endtask

    int          pers  [4] = '{4, 3, 2, 8};
    logic [1:0]  codes [4] = '{2'b10, 2'b00, 2'b01, 2'b11};

    initial begin
        checks   = 0;
        failures = 0;
        err_cnt  = 0;
        rst_n    = 1'b0;
        din      = 1'b0;

        do_reset();
        check("rst_locked", locked, 0);
        check("rst_sel", sel_det, 0);
        check("rst_period", period, 0);
        check("rst_err", err, 0);

        // Lock on each legal ratio: reference edge + 4 matching periods
        for (int i = 0; i < 4; i++) begin
            do_reset();
            send(pers[i], 4);
            check("prelock", locked, 0);
            cyc(1'b1);
            check("lock", locked, 1);
            check("lock_sel", sel_det, codes[i]);
            check("lock_period", period, pers[i]);
            check("lock_noerr", err_cnt, 0);
        end

        // Ratio change 2 -> 8: drop lock silently, relock after 3 more edges
        do_reset();
        send(2, 5);
        check("p2_locked", locked, 1);
        gap(6);
        cyc(1'b1);
        check("chg_unlock", locked, 0);
        check("chg_period", period, 8);
        gap(7); cyc(1'b1);
        gap(7); cyc(1'b1);
        check("chg_prelock", locked, 0);
        gap(7); cyc(1'b1);
        check("chg_relock", locked, 1);
        check("chg_sel", sel_det, 2'b11);
        check("chg_noerr", err_cnt, 0);

        // Loss of signal: single err 12 cycles after the last edge
        do_reset();
        send(4, 4);
        cyc(1'b1);
        err_cnt = 0;
        gap(11);
        check("to_early", err_cnt, 0);
        check("to_still_locked", locked, 1);
        cyc(1'b0);
        check("to_err", err, 1);
        check("to_unlock", locked, 0);
        check("to_sel_hold", sel_det, 2'b10);
        gap(20);
        check("to_single_err", err_cnt, 1);
        // From IDLE the next edge is reference only
        send(4, 4);
        check("to_idle_prelock", locked, 0);
        cyc(1'b1);
        check("to_idle_relock", locked, 1);

        // Illegal period 5 in ACQ clears the match count
        do_reset();
        cyc(1'b1);
        gap(3);
        cyc(1'b1);
        gap(4);
        cyc(1'b1);
        check("ill_err", err, 1);
        check("ill_period", period, 5);
        cyc(1'b0);
        check("ill_err_clear", err, 0);
        gap(2);
        send(4, 3);
        check("ill_prelock", locked, 0);
        cyc(1'b1);
        check("ill_lock", locked, 1);
        check("ill_sel", sel_det, 2'b10);

        // Wide pulse while locked
        gap(3);
        cyc(1'b1);
        check("wide_pre", locked, 1);
        err_cnt = 0;
        cyc(1'b1);
        check("wide_err", err, 1);
        check("wide_unlock", locked, 0);
        cyc(1'b0);
        check("wide_err_once", err_cnt, 1);

        // Reset while locked
        do_reset();
        send(2, 4);
        cyc(1'b1);
        check("rl_locked", locked, 1);
        rst_n = 1'b0;
        cyc(1'b0);
        check("rl_locked0", locked, 0);
        check("rl_sel0", sel_det, 0);
        check("rl_period0", period, 0);
        check("rl_err0", err, 0);
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
